// File: rtl/trap_dispatch.sv
// trap_dispatch: turns an encoder trap request into a fetch redirect.
// Flush, save the faulting PC, hand the vector to fetch, hold until rett.
module trap_dispatch #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trap_valid,
   input  logic [3:0]        TRAPreason,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [ADDR_W-13:0] tba,
   input  logic              rett,
   input  logic              vec_ready,
   output logic              flush,
   output logic [ADDR_W-1:0] trap_pc,
   output logic              vec_valid,
   output logic [ADDR_W-1:0] vec_addr,
   output logic [9:0]        src_ack,
   output logic              bad_code,
   output logic              err_mode,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      SAVE,
      VECTOR,
      HOLD
   } state_t;

   state_t     state;
   state_t     state_d;
   logic [3:0] cnt;
   logic [3:0] cnt_d;
   logic [3:0] code_q;
   logic       legal;
   logic       take;
   logic       hs;
   logic [9:0] ack_vec;

   assign legal   = (TRAPreason >= 4'd1) && (TRAPreason <= 4'd10);
   assign ack_vec = 10'd1 << (code_q - 4'd1);

   assign flush     = (state == FLUSH);
   assign vec_valid = (state == VECTOR);
   assign busy      = (state != IDLE);

   // State and flush counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state, counter and handshake decode
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      take    = 1'b0;
      hs      = 1'b0;
      unique case (state)
         IDLE: begin
            if (trap_valid && legal) begin
               state_d = FLUSH;
               cnt_d   = 4'(FLUSH_CYCLES - 1);
               take    = 1'b1;
            end
         end
         FLUSH: begin
            if (cnt == 4'd0) begin
               state_d = SAVE;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         SAVE: begin
            state_d = VECTOR;
         end
         VECTOR: begin
            if (vec_ready) begin
               hs      = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (rett) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Captured trap context, ack pulse, error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q   <= '0;
         trap_pc  <= '0;
         vec_addr <= '0;
         src_ack  <= '0;
         bad_code <= 1'b0;
         err_mode <= 1'b0;
      end else begin
         bad_code <= (state == IDLE) && trap_valid && !legal;
         src_ack  <= hs ? ack_vec : '0;
         if (take) begin
            code_q <= TRAPreason;
         end
         if (state == SAVE) begin
            trap_pc  <= pc_in;
            vec_addr <= {tba, 4'h0, code_q, 4'h0};
         end
         if ((state == HOLD) && trap_valid && legal && !rett) begin
            err_mode <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trap_dispatch.sv
// tb_trap_dispatch: directed vectors, scoreboard checks every vector
// handshake and the src_ack pulse that follows it.
module tb_trap_dispatch;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] pc;
      logic [3:0]  code;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        tv   [2];
   logic [3:0]  rs   [2];
   logic [31:0] pcv  [2];
   logic [19:0] tbav [2];
   logic        rt   [2];
   logic        rdy  [2];
   logic        fl   [2];
   logic [31:0] tpc  [2];
   logic        vv   [2];
   logic [31:0] va   [2];
   logic [9:0]  ack  [2];
   logic        bc   [2];
   logic        em   [2];
   logic        bz   [2];

   exp_t sbq [2][$];
   int   n_cmp;
   int   n_err;

   trap_dispatch #(.ADDR_W(32), .FLUSH_CYCLES(3)) u0 (
      .clk(clk), .rst(rst),
      .trap_valid(tv[0]), .TRAPreason(rs[0]),
      .pc_in(pcv[0]), .tba(tbav[0]),
      .rett(rt[0]), .vec_ready(rdy[0]),
      .flush(fl[0]), .trap_pc(tpc[0]),
      .vec_valid(vv[0]), .vec_addr(va[0]),
      .src_ack(ack[0]), .bad_code(bc[0]),
      .err_mode(em[0]), .busy(bz[0])
   );

   trap_dispatch #(.ADDR_W(32), .FLUSH_CYCLES(1)) u1 (
      .clk(clk), .rst(rst),
      .trap_valid(tv[1]), .TRAPreason(rs[1]),
      .pc_in(pcv[1]), .tba(tbav[1]),
      .rett(rt[1]), .vec_ready(rdy[1]),
      .flush(fl[1]), .trap_pc(tpc[1]),
      .vec_valid(vv[1]), .vec_addr(va[1]),
      .src_ack(ack[1]), .bad_code(bc[1]),
      .err_mode(em[1]), .busy(bz[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic chk_zero(input int d, input string nm);
      chk({nm, "_bits"}, {59'd0, fl[d], vv[d], bc[d], em[d], bz[d]}, 64'd0);
      chk({nm, "_trap_pc"}, {32'd0, tpc[d]}, 64'd0);
      chk({nm, "_vec_addr"}, {32'd0, va[d]}, 64'd0);
      chk({nm, "_src_ack"}, {54'd0, ack[d]}, 64'd0);
   endtask

   // Scoreboard monitors: pop on handshake, check ack one cycle later
   for (genvar g = 0; g < 2; g++) begin : g_mon
      initial begin
         logic [9:0] exp_ack;
         exp_t       e;
         exp_ack = '0;
         forever begin
            @(negedge clk);
            #2;
            chk($sformatf("src_ack%0d", g), {54'd0, ack[g]}, {54'd0, exp_ack});
            exp_ack = '0;
            if (!rst && vv[g] && rdy[g]) begin
               if (sbq[g].size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL sb_unexpected%0d: got vector %0h want none",
                           g, va[g]);
               end else begin
                  e = sbq[g].pop_front();
                  chk($sformatf("vec_addr%0d", g), {32'd0, va[g]}, {32'd0, e.addr});
                  chk($sformatf("trap_pc%0d", g), {32'd0, tpc[g]}, {32'd0, e.pc});
                  exp_ack = 10'd1 << (e.code - 4'd1);
               end
            end
         end
      end
   end

   // Issue one trap, count flush cycles, stall fetch, finish handshake
   task automatic run_trap(input int d, input logic [3:0] code,
                           input logic [31:0] p, input logic [19:0] t,
                           input int delay, input int fc);
      exp_t        e;
      int          cyc;
      int          nfl;
      int          first;
      int          stalls;
      bit          hs;
      logic [31:0] a0;
      e.addr = {t, 4'h0, code, 4'h0};
      e.pc   = p;
      e.code = code;
      sbq[d].push_back(e);
      tv[d]   = 1'b1;
      rs[d]   = code;
      pcv[d]  = p;
      tbav[d] = t;
      rdy[d]  = (delay == 0);
      cyc = 0; nfl = 0; first = -1; stalls = 0; hs = 0; a0 = '0;
      while (!hs && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (fl[d]) nfl++;
         if (vv[d]) begin
            if (first < 0) begin
               first = cyc;
               a0    = va[d];
               chk("trap_pc_at_vec", {32'd0, tpc[d]}, {32'd0, p});
            end else begin
               chk("vec_stable", {32'd0, va[d]}, {32'd0, a0});
            end
            if (!rdy[d]) begin
               stalls++;
               if (stalls > delay) rdy[d] = 1'b1;
            end
            if (rdy[d]) hs = 1;
         end
      end
      if (!hs) begin
         n_cmp++;
         n_err++;
         $display("FAIL handshake_timeout: got none want vec_valid");
      end
      chk("flush_cycles", 64'(nfl), 64'(fc));
      chk("vec_latency", 64'(first), 64'(fc + 2));
      @(negedge clk);
      chk("post_hs", {62'd0, vv[d], bz[d]}, 64'd1);
      tv[d] = 1'b0;
   endtask

   task automatic do_rett(input int d);
      rt[d] = 1'b1;
      @(negedge clk);
      rt[d] = 1'b0;
      chk("rett_idle", {63'd0, bz[d]}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tv[i] = 0; rs[i] = 0; pcv[i] = 0;
         tbav[i] = 0; rt[i] = 0; rdy[i] = 0;
      end
      @(negedge clk);
      @(negedge clk);
      chk_zero(0, "reset0");
      chk_zero(1, "reset1");
      rst = 1'b0;
      @(negedge clk);

      // Basic trap, code 3
      run_trap(0, 4'h3, 32'h0000_1040, 20'hABCDE, 0, 3);
      @(negedge clk);
      chk("hold_busy", {63'd0, bz[0]}, 64'd1);
      do_rett(0);

      // Fetch stalls four cycles
      run_trap(0, 4'h7, 32'h0000_2200, 20'h12345, 4, 3);
      do_rett(0);

      // Illegal codes in IDLE
      tv[0] = 1'b1;
      rs[0] = 4'h0;
      @(negedge clk);
      chk("bad0", {61'd0, bc[0], fl[0], bz[0]}, 64'h4);
      rs[0] = 4'hC;
      @(negedge clk);
      chk("badC", {61'd0, bc[0], fl[0], bz[0]}, 64'h4);
      tv[0] = 1'b0;
      @(negedge clk);
      chk("bad_clear", {63'd0, bc[0]}, 64'd0);

      // Trap while in HOLD sets sticky err_mode
      run_trap(0, 4'h2, 32'h0000_3000, 20'h00001, 0, 3);
      @(negedge clk);
      tv[0] = 1'b1;
      rs[0] = 4'h5;
      @(negedge clk);
      chk("err_set", {62'd0, em[0], bz[0]}, 64'h3);
      tv[0] = 1'b0;
      do_rett(0);
      chk("err_sticky", {63'd0, em[0]}, 64'd1);
      rst = 1'b1;
      #1;
      chk("err_rst", {63'd0, em[0]}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // rett and new trap together: rett wins, trap follows
      run_trap(0, 4'h4, 32'h0000_4000, 20'hFEDCB, 0, 3);
      @(negedge clk);
      tv[0] = 1'b1;
      rs[0] = 4'h5;
      rt[0] = 1'b1;
      @(negedge clk);
      chk("rett_wins", {61'd0, em[0], bz[0], fl[0]}, 64'd0);
      rt[0] = 1'b0;
      @(negedge clk);
      chk("new_trap", {63'd0, fl[0]}, 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_zero(0, "rst_flush");
      tv[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero(0, "post_rst_flush");

      // Reset while presenting the vector
      tv[0]   = 1'b1;
      rs[0]   = 4'h6;
      pcv[0]  = 32'h0000_5550;
      tbav[0] = 20'h0F0F0;
      rdy[0]  = 1'b0;
      n = 0;
      while (!vv[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vector", {63'd0, vv[0]}, 64'd1);
      rst = 1'b1;
      #1;
      chk_zero(0, "rst_vector");
      tv[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero(0, "post_rst_vector");

      // Single flush cycle, highest code, all-ones base
      run_trap(1, 4'hA, 32'h8000_0004, 20'hFFFFF, 0, 1);
      @(negedge clk);
      do_rett(1);

      @(negedge clk);
      @(negedge clk);
      chk("sb_empty", 64'(sbq[0].size() + sbq[1].size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
